reset_sequencer: RTL and testbench

//   Consumes the synchronized active-low reset and releases NUM_STAGES downstream

---
 rtl/reset_sequencer.sv | 105 ++++++++++
 tb/tb_reset_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_STAGES reset domains in order, each after a delay and followed by an ack wait with timeout.
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int DELAY_W     = 8,
  parameter int STAGE_DELAY = 16,
  parameter int ACK_TIMEOUT = 64,
  parameter int SW_HOLD     = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  sw_rst_req_i,
  input  logic [NUM_STAGES-1:0] stage_ack_i,
  output logic [NUM_STAGES-1:0] rstn_stage_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic [NUM_STAGES-1:0] err_o
);
  localparam int IW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_STAGES - 1);
  localparam logic [DELAY_W-1:0] DLY_LAST = DELAY_W'(STAGE_DELAY - 1);
  localparam logic [DELAY_W-1:0] TMO_LAST = DELAY_W'(ACK_TIMEOUT > 0 ? ACK_TIMEOUT - 1 : 0);
  localparam logic [DELAY_W-1:0] HOLD_LAST = DELAY_W'(SW_HOLD - 1);

  typedef enum logic [1:0] {DELAY, WAIT_ACK, DONE, HOLD} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DELAY_W-1:0]    cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic [NUM_STAGES-1:0] err_q, err_d;
  logic                  done_q, done_d;
  logic                  busy_q;
  logic                  ack_ok, tmo;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    stage_d = stage_q;
    err_d   = err_q;
    done_d  = done_q;
    ack_ok  = stage_ack_i[idx_q] | (ACK_TIMEOUT == 0);
    tmo     = (ACK_TIMEOUT != 0) && (cnt_q == TMO_LAST);
    if (sw_rst_req_i) begin
      state_d = HOLD;
      idx_d   = '0;
      cnt_d   = '0;
      stage_d = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        DELAY: if (cnt_q == DLY_LAST) begin
          stage_d[idx_q] = 1'b1;
          cnt_d          = '0;
          state_d        = WAIT_ACK;
        end
        WAIT_ACK: begin
          // an ack arriving on the timeout cycle wins, so no error is flagged
          if (!ack_ok && tmo) err_d[idx_q] = 1'b1;
          if (ack_ok || tmo) begin
            if (idx_q == LAST) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              cnt_d   = '0;
              state_d = DELAY;
            end
          end
        end
        DONE: cnt_d = cnt_q;
        HOLD: if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = DELAY;
        end
        default: state_d = DELAY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= DELAY;
      idx_q   <= '0;
      cnt_q   <= '0;
      stage_q <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= state_d != DONE;
    end
  end

  assign rstn_stage_o = stage_q;
  assign done_o       = done_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scenarios on a 4-stage sequencer and a 1-stage no-ack variant.
module tb_reset_sequencer;
  logic       clk = 1'b0;
  logic       rstn = 1'b0, req = 1'b0;
  logic [3:0] ack = 4'hF;
  logic [3:0] stg, err;
  logic       done, busy;
  logic       rstn2 = 1'b0;
  logic [0:0] stg2, err2;
  logic       done2, busy2;
  int         n_cmp = 0, n_bad = 0;
  logic [9:0] got, exp;

  always #5 clk = ~clk;

  reset_sequencer dut (
    .clk_i(clk), .rstn_i(rstn), .sw_rst_req_i(req), .stage_ack_i(ack),
    .rstn_stage_o(stg), .done_o(done), .busy_o(busy), .err_o(err)
  );

  reset_sequencer #(.NUM_STAGES(1), .ACK_TIMEOUT(0)) dut1 (
    .clk_i(clk), .rstn_i(rstn2), .sw_rst_req_i(1'b0), .stage_ack_i(1'b0),
    .rstn_stage_o(stg2), .done_o(done2), .busy_o(busy2), .err_o(err2)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rel(input int e, input int r0, input int r1, input int r2, input int r3);
    return {e >= r3, e >= r2, e >= r1, e >= r0};
  endfunction

  task automatic test_reset;
    rstn = 1'b0; req = 1'b0; ack = 4'hF;
    tick(5);
    got = {stg, done, busy, err}; exp = {4'b0, 1'b0, 1'b1, 4'b0};
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL reset got %b want %b", got, exp); end
  endtask

  task automatic test_powerup;
    rstn = 1'b1;
    for (int e = 1; e <= 68; e++) begin
      tick(1);
      got = {stg, done, busy, err}; exp = {rel(e, 16, 33, 50, 67), e >= 68, e < 68, 4'b0};
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL powerup edge %0d got %b want %b", e, got, exp); end
    end
  endtask

  task automatic test_ack_stall;
    rstn = 1'b0; tick(2); rstn = 1'b1; ack = 4'b1101;
    for (int e = 1; e <= 131; e++) begin
      tick(1);
      got = {stg, done, busy, err};
      exp = {rel(e, 16, 33, 113, 130), e >= 131, e < 131, e >= 97 ? 4'b0010 : 4'b0000};
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL ack_stall edge %0d got %b want %b", e, got, exp); end
    end
    ack = 4'hF;
  endtask

  task automatic test_sw_done;
    req = 1'b1; tick(1); req = 1'b0;
    got = {stg, done, busy, err}; exp = {4'b0, 1'b0, 1'b1, 4'b0010};
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL sw_done_drop got %b want %b", got, exp); end
    for (int e = 1; e <= 76; e++) begin
      tick(1);
      got = {stg, done, busy, err}; exp = {rel(e, 24, 41, 58, 75), e >= 76, e < 76, 4'b0010};
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL sw_done edge %0d got %b want %b", e, got, exp); end
    end
  endtask

  task automatic test_sw_mid;
    ack = 4'b1101;
    req = 1'b1; tick(1); req = 1'b0;
    tick(41);
    got = {stg, done, busy, err}; exp = {4'b0011, 1'b0, 1'b1, 4'b0010};
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL sw_mid_pre got %b want %b", got, exp); end
    tick(5);
    req = 1'b1; tick(1);
    got = {stg, done, busy, err}; exp = {4'b0, 1'b0, 1'b1, 4'b0010};
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL sw_mid_drop got %b want %b", got, exp); end
    ack = 4'hF;
    tick(2); req = 1'b0;
    for (int e = 3; e <= 78; e++) begin
      tick(1);
      got = {stg, done, busy, err}; exp = {rel(e, 26, 43, 60, 77), e >= 78, e < 78, 4'b0010};
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL sw_mid edge %0d got %b want %b", e, got, exp); end
    end
  endtask

  task automatic test_late_ack;
    rstn = 1'b0; tick(2); rstn = 1'b1; ack = 4'b1011;
    for (int e = 1; e <= 130; e++) begin
      if (e == 113) ack = 4'hF;
      tick(1);
      got = {stg, done, busy, err}; exp = {rel(e, 16, 33, 50, 129), e >= 130, e < 130, 4'b0};
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL late_ack edge %0d got %b want %b", e, got, exp); end
    end
  endtask

  task automatic test_rstn_mid;
    rstn = 1'b0; tick(2); rstn = 1'b1; ack = 4'b1001;
    tick(120);
    got = {stg, done, busy, err}; exp = {4'b0111, 1'b0, 1'b1, 4'b0010};
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rstn_mid_pre got %b want %b", got, exp); end
    rstn = 1'b0; tick(1);
    got = {stg, done, busy, err}; exp = {4'b0, 1'b0, 1'b1, 4'b0};
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rstn_mid_drop got %b want %b", got, exp); end
    rstn = 1'b1; ack = 4'hF;
    for (int e = 1; e <= 68; e++) begin
      tick(1);
      got = {stg, done, busy, err}; exp = {rel(e, 16, 33, 50, 67), e >= 68, e < 68, 4'b0};
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rstn_mid edge %0d got %b want %b", e, got, exp); end
    end
  endtask

  task automatic test_single_noack;
    rstn2 = 1'b0; tick(2);
    got = {3'b0, stg2, done2, busy2, 3'b0, err2}; exp = {3'b0, 1'b0, 1'b0, 1'b1, 4'b0};
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL single_reset got %b want %b", got, exp); end
    rstn2 = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick(1);
      got = {3'b0, stg2, done2, busy2, 3'b0, err2};
      exp = {3'b0, e >= 16, e >= 17, e < 17, 4'b0};
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL single edge %0d got %b want %b", e, got, exp); end
    end
  endtask

  initial begin
    test_reset;
    test_powerup;
    test_ack_stall;
    test_sw_done;
    test_sw_mid;
    test_late_ack;
    test_rstn_mid;
    test_single_noack;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
